// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared owner encoding and default depth for sram_req_arbiter
package sram_arb_pkg;
    localparam int   DEFAULT_DEPTH = 4;
    localparam logic OWN_INST      = 1'b0;
    localparam logic OWN_DATA      = 1'b1;
endpackage

// File: rtl/sram_req_arbiter_if.sv
// rtl/sram_req_arbiter_if.sv - SRAM-like request/response bundle with master and slave views
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, wr, wstrb, addr, wdata,
                    input  addr_ok, data_ok, rdata);
    modport slave  (input  req, wr, wstrb, addr, wdata,
                    output addr_ok, data_ok, rdata);
    // Read-only requester view: no write controls are carried.
    modport rd_slave (input  req, addr,
                      output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_req_arbiter_owner_tag_fifo.sv
// rtl/sram_req_arbiter_owner_tag_fifo.sv - 1-bit owner tag FIFO recording in-flight transaction order
module owner_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     push_tag,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - inst/data SRAM-like port arbiter with in-order response routing; ARB_ROUND_ROBIN_EN selects round-robin
module sram_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         resetn,
    sram_req_arbiter_if.rd_slave         inst,
    sram_req_arbiter_if.slave            data,
    sram_req_arbiter_if.master           s,
    output logic                         err_unexp_resp
);
    localparam int AW = $clog2(DEPTH);

    logic          pick;
    logic          grant;
    logic          grant_req;
    logic          handshake;
    logic          pop;
    logic          lock;
    logic          lock_owner;
    logic          q_head;
    logic          q_full;
    logic          q_empty;
    logic [AW:0]   q_count;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_owner;
`endif

    always_comb begin
        pick = OWN_INST;
        if (data.req && inst.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick = ~last_owner;
`else
            pick = OWN_DATA;
`endif
        end else if (data.req) begin
            pick = OWN_DATA;
        end
        grant = lock ? lock_owner : pick;
    end

    assign grant_req = (grant == OWN_DATA) ? data.req : inst.req;
    assign s.req     = resetn & ~q_full & grant_req;
    assign handshake = s.req & s.addr_ok;

    assign s.addr  = (grant == OWN_DATA) ? data.addr  : inst.addr;
    assign s.wdata = (grant == OWN_DATA) ? data.wdata : 32'h0;
    assign s.wstrb = (grant == OWN_DATA) ? data.wstrb : 4'b0;
    assign s.wr    = resetn & (grant == OWN_DATA) & data.wr;

    assign inst.addr_ok = handshake & (grant == OWN_INST);
    assign data.addr_ok = handshake & (grant == OWN_DATA);

    assign pop          = resetn & s.data_ok & ~q_empty;
    assign inst.data_ok = pop & (q_head == OWN_INST);
    assign data.data_ok = pop & (q_head == OWN_DATA);
    assign inst.rdata   = s.rdata;
    assign data.rdata   = s.rdata;

    owner_tag_fifo #(.DEPTH(DEPTH)) u_owner_q (
        .clk      (clk),
        .resetn   (resetn),
        .push     (handshake),
        .push_tag (grant),
        .pop      (pop),
        .head     (q_head),
        .full     (q_full),
        .empty    (q_empty),
        .count    (q_count)
    );

    // A presented but unaccepted request pins the grant until its handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock           <= 1'b0;
            lock_owner     <= OWN_INST;
            err_unexp_resp <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner     <= OWN_INST;
`endif
        end else begin
            lock       <= s.req & ~s.addr_ok;
            lock_owner <= grant;
            if (s.data_ok && (q_count == '0)) begin
                err_unexp_resp <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (handshake) begin
                last_owner <= grant;
            end
`endif
        end
    end
endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - self-checking bench for sram_req_arbiter with a queue-based reference model
module tb_sram_req_arbiter;
    import sram_arb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic err;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if s_if ();

    sram_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst           (inst_if),
        .data           (data_if),
        .s              (s_if),
        .err_unexp_resp (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    bit          mq[$];
    bit          m_err, m_pend, m_pend_own, m_last;
    logic [31:0] grant_log[$];
    logic [31:0] inst_rx[$];
    logic [31:0] data_rx[$];
    logic        obs_sreq, obs_swr, obs_iaok, obs_daok, obs_idok, obs_ddok, obs_err;
    logic [31:0] obs_saddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit g, esreq, ehs, epop, full, head;
        @(negedge clk);
        full = (mq.size() == DEPTH);
        head = (mq.size() > 0) ? mq[0] : 1'b0;
        if (m_pend) begin
            g = m_pend_own;
        end else if (inst_if.req && data_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
            g = ~m_last;
`else
            g = 1'b1;
`endif
        end else begin
            g = data_if.req;
        end
        esreq = resetn && !full && (g ? data_if.req : inst_if.req);
        ehs   = esreq && s_if.addr_ok;
        epop  = resetn && s_if.data_ok && (mq.size() > 0);

        chk("s_req", s_if.req, esreq);
        chk("inst_addr_ok", inst_if.addr_ok, ehs && !g);
        chk("data_addr_ok", data_if.addr_ok, ehs && g);
        chk("inst_data_ok", inst_if.data_ok, epop && !head);
        chk("data_data_ok", data_if.data_ok, epop && head);
        chk("err_unexp_resp", err, m_err);
        if (esreq) begin
            chk("s_addr", s_if.addr, g ? data_if.addr : inst_if.addr);
            chk("s_wr", s_if.wr, g ? data_if.wr : 1'b0);
            chk("s_wstrb", s_if.wstrb, g ? data_if.wstrb : 4'b0);
            if (g) chk("s_wdata", s_if.wdata, data_if.wdata);
        end
        if (epop) begin
            chk("inst_rdata", inst_if.rdata, s_if.rdata);
            chk("data_rdata", data_if.rdata, s_if.rdata);
        end

        obs_sreq  = s_if.req;
        obs_swr   = s_if.wr;
        obs_iaok  = inst_if.addr_ok;
        obs_daok  = data_if.addr_ok;
        obs_idok  = inst_if.data_ok;
        obs_ddok  = data_if.data_ok;
        obs_err   = err;
        obs_saddr = s_if.addr;
        if (inst_if.addr_ok) grant_log.push_back(32'd0);
        if (data_if.addr_ok) grant_log.push_back(32'd1);
        if (inst_if.data_ok) inst_rx.push_back(inst_if.rdata);
        if (data_if.data_ok) data_rx.push_back(data_if.rdata);

        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_last = 1'b0;
        end else begin
            if (s_if.data_ok && mq.size() == 0) m_err = 1'b1;
            if (epop) void'(mq.pop_front());
            if (ehs) begin
                mq.push_back(g);
                m_last = g;
            end
            m_pend     = esreq && !s_if.addr_ok;
            m_pend_own = g;
        end
        #1;
    endtask

    task automatic idle_inputs();
        inst_if.req   = 1'b0;
        data_if.req   = 1'b0;
        s_if.addr_ok  = 1'b0;
        s_if.data_ok  = 1'b0;
    endtask

    task automatic issue(input bit own, input logic [31:0] addr);
        idle_inputs();
        if (own) begin
            data_if.req  = 1'b1;
            data_if.addr = addr;
        end else begin
            inst_if.req  = 1'b1;
            inst_if.addr = addr;
        end
        s_if.addr_ok = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic respond(input logic [31:0] rd);
        idle_inputs();
        s_if.data_ok = 1'b1;
        s_if.rdata   = rd;
        cycle();
        idle_inputs();
    endtask

    initial begin
        inst_if.req = 1'b1; inst_if.addr = 32'h0; inst_if.wr = 1'b0;
        inst_if.wstrb = 4'b0; inst_if.wdata = 32'h0;
        data_if.req = 1'b1; data_if.addr = 32'h8000_0000; data_if.wr = 1'b1;
        data_if.wstrb = 4'hF; data_if.wdata = 32'h1234_5678;
        s_if.addr_ok = 1'b1; s_if.data_ok = 1'b1; s_if.rdata = 32'hDEAD_BEEF;

        // Reset with everything asserted.
        resetn = 1'b0;
        cycle();
        chk("reset_s_req", obs_sreq, 1'b0);
        chk("reset_s_wr", obs_swr, 1'b0);
        cycle();
        chk("reset_data_ok", {obs_idok, obs_ddok, obs_iaok, obs_daok}, 4'b0);
        data_if.wr = 1'b0;
        idle_inputs();
        resetn = 1'b1;
        cycle();
        chk("reset_err", obs_err, 1'b0);

        // Single read.
        issue(1'b0, 32'hBFC0_0000);
        cycle();
        respond(32'h3C1D_0000);
        cycle();
        chk("single_inst_cnt", inst_rx.size(), 1);
        if (inst_rx.size() > 0) chk("single_inst_rdata", inst_rx[0], 32'h3C1D_0000);
        chk("single_data_cnt", data_rx.size(), 0);

        // Contention until the queue is full.
        grant_log.delete();
        inst_if.req = 1'b1; inst_if.addr = 32'h0000_0100;
        data_if.req = 1'b1; data_if.addr = 32'h0000_0200; data_if.wstrb = 4'h3;
        s_if.addr_ok = 1'b1;
        repeat (4) cycle();
        chk("contention_cnt", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            chk("contention_rr", grant_log[i], (i % 2 == 0) ? 32'd1 : 32'd0);
`else
            chk("contention_fixed", grant_log[i], 32'd1);
`endif
        end
        s_if.data_ok = 1'b1; s_if.rdata = 32'h0000_00AA;
        cycle();
        chk("full_no_req", obs_sreq, 1'b0);
        chk("full_no_grant", {obs_iaok, obs_daok}, 2'b00);
        s_if.data_ok = 1'b0;
        cycle();
        chk("after_full_req", obs_sreq, 1'b1);
        idle_inputs();
        for (int i = 0; i < 4; i++) respond(32'h100 + i);

        // Lock: data stalled while inst rises.
        data_if.req = 1'b1; data_if.addr = 32'h1000_0010; data_if.wr = 1'b1;
        data_if.wstrb = 4'hF; data_if.wdata = 32'hCAFE_0001;
        s_if.addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                inst_if.req = 1'b1; inst_if.addr = 32'hBFC0_0004;
            end
            cycle();
            chk("lock_addr", obs_saddr, 32'h1000_0010);
            chk("lock_inst_aok", obs_iaok, 1'b0);
        end
        s_if.addr_ok = 1'b1;
        cycle();
        chk("lock_data_hs", obs_daok, 1'b1);
        data_if.req = 1'b0; data_if.wr = 1'b0;
        cycle();
        chk("lock_inst_hs", obs_iaok, 1'b1);
        idle_inputs();
        respond(32'h55);
        respond(32'h66);

        // Ordering.
        inst_rx.delete();
        data_rx.delete();
        issue(1'b0, 32'hA0);
        issue(1'b1, 32'hB0);
        issue(1'b1, 32'hB4);
        issue(1'b0, 32'hA4);
        for (int i = 1; i <= 4; i++) begin
            s_if.data_ok = 1'b1; s_if.rdata = i;
            cycle();
        end
        idle_inputs();
        chk("order_inst_cnt", inst_rx.size(), 2);
        chk("order_data_cnt", data_rx.size(), 2);
        if (inst_rx.size() == 2) begin
            chk("order_inst0", inst_rx[0], 32'd1);
            chk("order_inst1", inst_rx[1], 32'd4);
        end
        if (data_rx.size() == 2) begin
            chk("order_data0", data_rx[0], 32'd2);
            chk("order_data1", data_rx[1], 32'd3);
        end

        // Unexpected response, then reset mid-burst.
        respond(32'h77);
        cycle();
        chk("err_set", obs_err, 1'b1);
        issue(1'b0, 32'hC0);
        issue(1'b1, 32'hC4);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        cycle();
        chk("err_cleared", obs_err, 1'b0);
        for (int i = 0; i < 2; i++) begin
            respond(32'h88 + i);
            chk("post_reset_no_dok", {obs_idok, obs_ddok}, 2'b00);
        end
        cycle();
        chk("post_reset_err", obs_err, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
